ysyx_24100005_ifu: RTL and testbench

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

---
 rtl/ysyx_24100005_ifu.sv | 148 ++++++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_ifu.sv
// ysyx_24100005_ifu: instruction fetch unit with one outstanding read and redirect/drop handling.
// Optional macro YSYX_24100005_IFU_ALIGN_CHK_EN traps misaligned redirect targets in ERR. Rev 1.0
`default_nettype none

module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_rready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_araddr, w_araddr_nxt;
  logic [31:0] r_out_inst, w_out_inst_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        w_launch, w_launch_bad;
  logic [31:0] w_launch_pc, w_redir_pc;

`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
  assign w_redir_pc = redirect_pc;
  assign fetch_err  = (r_state == S_ERR);
`else
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_araddr   <= 32'd0;
      r_out_inst <= 32'd0;
      r_out_pc   <= 32'd0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_araddr   <= w_araddr_nxt;
      r_out_inst <= w_out_inst_nxt;
      r_out_pc   <= w_out_pc_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_araddr_nxt   = r_araddr;
    w_out_inst_nxt = r_out_inst;
    w_out_pc_nxt   = r_out_pc;
    w_drop_nxt     = r_drop;
    w_launch       = 1'b0;
    w_launch_pc    = r_pc;
    w_launch_bad   = 1'b0;
    mem_arvalid    = 1'b0;
    mem_rready     = 1'b0;
    out_valid      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_launch = 1'b1;
        if (redirect_valid) w_launch_pc = w_redir_pc;
      end
      S_AR: begin
        mem_arvalid = 1'b1;
        // The presented request must finish untouched; its response is dropped later.
        if (redirect_valid) begin
          w_pc_nxt   = w_redir_pc;
          w_drop_nxt = 1'b1;
        end
        if (mem_arready) w_state_nxt = S_R;
      end
      S_R: begin
        mem_rready = 1'b1;
        if (redirect_valid) begin
          w_pc_nxt   = w_redir_pc;
          w_drop_nxt = 1'b1;
        end
        if (mem_rvalid) begin
          if (r_drop || redirect_valid) begin
            w_drop_nxt  = 1'b0;
            w_launch    = 1'b1;
            w_launch_pc = redirect_valid ? w_redir_pc : r_pc;
          end else begin
            w_out_inst_nxt = mem_rdata;
            w_out_pc_nxt   = r_pc;
            w_state_nxt    = S_OUT;
          end
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (redirect_valid) begin
          w_launch    = 1'b1;
          w_launch_pc = w_redir_pc;
        end else if (out_ready) begin
          w_launch    = 1'b1;
          w_launch_pc = r_pc + 32'd4;
        end
      end
      S_ERR: begin
        mem_rready = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
    w_launch_bad = |w_launch_pc[1:0];
`endif

    // Every path that starts a new fetch funnels through here.
    if (w_launch) begin
      w_pc_nxt     = w_launch_pc;
      w_araddr_nxt = w_launch_pc;
      w_state_nxt  = w_launch_bad ? S_ERR : S_AR;
    end
  end

  assign mem_araddr = r_araddr;
  assign out_inst   = r_out_inst;
  assign out_pc     = r_out_pc;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100005_ifu.sv
// tb_ysyx_24100005_ifu: directed scenarios plus randomized traffic against a transaction-level model.
// Honours YSYX_24100005_IFU_ALIGN_CHK_EN for the misaligned-redirect scenario. Rev 1.0
`default_nettype none

module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        fetch_err;

  ysyx_24100005_ifu #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_deliv = 0;
  int idle_run = 0;

  logic        use_fixed = 1'b1;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_addr = 32'd0;
  logic [31:0] m_next = RPC;
  logic [31:0] m_req_addr = 32'd0;
  logic        m_live = 1'b0;
  logic        m_err = 1'b0;
  logic        p_arvalid = 1'b0, p_arready = 1'b0, p_out_valid = 1'b0, p_out_ready = 1'b0;
  logic        p_redir = 1'b0, p_rhs = 1'b0, p_rhs_live = 1'b0;
  logic [31:0] p_araddr = 32'd0, p_inst = 32'd0, p_pc = 32'd0;

  function automatic logic [31:0] memf(input logic [31:0] a, input logic fixed);
    if (fixed) return 32'h0010_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = memf(m_pend_addr, use_fixed);

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: next fetch address, liveness of the in-flight fetch, handshake rules.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("reset_valids_low", |{mem_arvalid, mem_rready, out_valid, fetch_err}, 1'b0);
      chk32("reset_out_inst", out_inst, 32'd0);
      chk32("reset_out_pc", out_pc, 32'd0);
      m_next = RPC; m_live = 1'b0; m_err = 1'b0; m_pend = 1'b0; idle_run = 0;
      p_arvalid = 1'b0; p_arready = 1'b0; p_out_valid = 1'b0; p_out_ready = 1'b0;
      p_redir = 1'b0; p_rhs = 1'b0; p_rhs_live = 1'b0;
    end else begin
      chk1("single_channel_active", (int'(mem_arvalid) + int'(mem_rready) + int'(out_valid)) <= 1, 1'b1);
`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
      if (!m_err) chk1("fetch_err_clear", fetch_err, 1'b0);
`else
      chk1("fetch_err_tied", fetch_err, 1'b0);
`endif
      if (!m_err) chk1("rready_iff_pending", mem_rready, m_pend);
      if (mem_arvalid || mem_rready || out_valid || m_err) idle_run = 0;
      else idle_run++;
      chk1("no_stall", idle_run <= 1, 1'b1);

      if (p_arvalid && !p_arready) begin
        chk1("ar_hold_valid", mem_arvalid, 1'b1);
        chk32("ar_hold_addr", mem_araddr, p_araddr);
      end
      if (p_out_valid) begin
        if (p_out_ready || p_redir) begin
          chk1("out_drop", out_valid, 1'b0);
          if (!m_err) chk1("refetch_after_out", mem_arvalid, 1'b1);
        end else begin
          chk1("out_hold_valid", out_valid, 1'b1);
          chk32("out_hold_inst", out_inst, p_inst);
          chk32("out_hold_pc", out_pc, p_pc);
          chk1("out_no_req", mem_arvalid, 1'b0);
        end
      end
      if (p_rhs) begin
        chk1("resp_delivers", out_valid, p_rhs_live);
        if (!p_rhs_live && !m_err) chk1("refetch_after_drop", mem_arvalid, 1'b1);
      end
      if (out_valid && !p_out_valid) begin
        chk1("deliver_live", m_live, 1'b1);
        chk32("deliver_pc", out_pc, m_req_addr);
        chk32("deliver_inst", out_inst, memf(m_req_addr, use_fixed));
      end
      if (m_err && !p_arvalid) chk1("err_no_request", mem_arvalid, 1'b0);
      if (mem_arvalid && !p_arvalid && !m_err) begin
        chk32("issue_addr", mem_araddr, m_next);
        m_req_addr = mem_araddr;
        m_live = 1'b1;
        m_next = mem_araddr + 32'd4;
      end

      if (out_valid && out_ready) begin
        n_deliv++;
        m_live = 1'b0;
      end
      if (redirect_valid && !m_err) begin
        m_live = 1'b0;
        m_next = redirect_pc & 32'hFFFF_FFFC;
`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
`endif
      end
      if (mem_arvalid && mem_arready) begin
        m_pend = 1'b1;
        m_pend_addr = mem_araddr;
      end
      p_rhs = mem_rvalid && mem_rready;
      if (p_rhs) begin
        m_pend = 1'b0;
        p_rhs_live = m_live;
      end

      p_arvalid = mem_arvalid; p_arready = mem_arready; p_araddr = mem_araddr;
      p_out_valid = out_valid; p_out_ready = out_ready; p_redir = redirect_valid;
      p_inst = out_inst; p_pc = out_pc;
    end
  end

  initial begin
    repeat (3) tick();
    chk1("init_valids_low", |{mem_arvalid, mem_rready, out_valid}, 1'b0);
    chk32("init_out_pc", out_pc, 32'd0);
    chk32("init_out_inst", out_inst, 32'd0);

    // Free-flowing memory: one instruction per three cycles.
    mem_arready = 1'b1; mem_rvalid = 1'b1; out_ready = 1'b1; rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk1("seq_arvalid", mem_arvalid, (k % 3) == 1);
      chk1("seq_out_valid", out_valid, (k % 3) == 0);
      if ((k % 3) == 1) chk32("seq_araddr", mem_araddr, 32'h8000_0000 + 32'((k - 1) / 3 * 4));
      if ((k % 3) == 0) begin
        chk32("seq_out_inst", out_inst, 32'h0010_0093);
        chk32("seq_out_pc", out_pc, 32'h8000_0000 + 32'((k - 3) / 3 * 4));
      end
    end

    // Backpressure on both the address channel and the output channel.
    rst = 1'b0; tick();
    mem_arready = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk1("ar_stall_valid", mem_arvalid, 1'b1);
      chk32("ar_stall_addr", mem_araddr, 32'h8000_0000);
      if (k == 4) mem_arready = 1'b1;
      tick();
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      chk1("out_stall_valid", out_valid, 1'b1);
      chk32("out_stall_pc", out_pc, 32'h8000_0000);
      chk32("out_stall_inst", out_inst, 32'h0010_0093);
      chk1("out_stall_noreq", mem_arvalid, 1'b0);
      if (k == 3) out_ready = 1'b1;
      tick();
    end
    chk32("after_stall_araddr", mem_araddr, 32'h8000_0004);

    // Redirect while the response is being returned.
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk1("redir_r_no_out", out_valid, 1'b0);
    chk1("redir_r_arvalid", mem_arvalid, 1'b1);
    chk32("redir_r_araddr", mem_araddr, 32'h8000_0100);
    tick(); tick();
    chk32("redir_r_deliver_pc", out_pc, 32'h8000_0100);

    // Redirect together with consumption in OUT.
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk1("redir_out_no_valid", out_valid, 1'b0);
    chk32("redir_out_araddr", mem_araddr, 32'h8000_0200);

    // Redirect during AR to the top of the address space, then wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk32("wrap_top_araddr", mem_araddr, 32'hFFFF_FFFC);
    tick(); tick();
    chk32("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    chk1("wrap_arvalid", mem_arvalid, 1'b1);
    chk32("wrap_next_araddr", mem_araddr, 32'h0000_0000);

    // Asynchronous reset in the middle of R.
    tick();
    chk1("mid_r_rready", mem_rready, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("async_rst_valids", |{mem_arvalid, mem_rready, out_valid, fetch_err}, 1'b0);
    chk32("async_rst_araddr", mem_araddr, 32'd0);
    chk32("async_rst_out_pc", out_pc, 32'd0);
    chk32("async_rst_out_inst", out_inst, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk1("restart_arvalid", mem_arvalid, 1'b1);
    chk32("restart_araddr", mem_araddr, RPC);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
    for (int k = 0; k < 3; k++) begin
      chk1("misalign_fetch_err", fetch_err, 1'b1);
      chk1("misalign_no_arvalid", mem_arvalid, 1'b0);
      tick();
    end
`else
    chk1("misalign_arvalid", mem_arvalid, 1'b1);
    chk32("misalign_araddr", mem_araddr, 32'h8000_0100);
    chk1("misalign_fetch_err", fetch_err, 1'b0);
`endif

    // Randomized traffic with occasional resets.
    rst = 1'b0; use_fixed = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst = 1'b0;
      mem_arready = ($urandom_range(0, 3) != 0);
      mem_rvalid = m_pend ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom();
`ifdef YSYX_24100005_IFU_ALIGN_CHK_EN
      redirect_pc[1:0] = 2'b00;
`endif
    end
    redirect_valid = 1'b0;
    tick();
    chk1("random_progress", n_deliv > 20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
